// File: rtl/led_sequencer.sv
// One-hot LED position sequencer: rotate-left/right, bounce, freeze.
// Bounce mode and its direction flop exist only with LED_SEQ_BOUNCE_EN.
module led_sequencer #(
    parameter int N_LED    = 8,
    parameter int STEP_DIV = 600
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     step_now,
    output logic [N_LED-1:0]         led_select,
    output logic [$clog2(N_LED)-1:0] led_pos,
    output logic                     step_pulse
);

    localparam int PW = $clog2(N_LED);
    localparam int CW = $clog2(STEP_DIV + 1);

    localparam logic [PW-1:0] POS_MAX  = PW'(N_LED - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        M_ROL = 2'b00,
        M_ROR = 2'b01,
        M_BNC = 2'b10,
        M_FRZ = 2'b11
    } mode_e;

    mode_e mode_s;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [N_LED-1:0] sel_q, sel_d;
    logic             pulse_q, pulse_d;
    logic             step;
    logic [PW-1:0]    pos_up, pos_dn;

    assign mode_s = mode_e'(mode);

    // Wrapping neighbours of the current position
    assign pos_up = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
    assign pos_dn = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (step_now) begin
            cnt_d = '0;
            step  = 1'b1;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

`ifdef LED_SEQ_BOUNCE_EN
    logic dir_q, dir_d;

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (step) begin
            unique case (mode_s)
                M_ROL: pos_d = pos_up;
                M_ROR: pos_d = pos_dn;
                M_BNC: begin
                    if (dir_q && pos_q == POS_MAX) begin
                        dir_d = 1'b0;
                        pos_d = POS_MAX - PW'(1);
                    end else if (!dir_q && pos_q == '0) begin
                        dir_d = 1'b1;
                        pos_d = PW'(1);
                    end else if (dir_q) begin
                        pos_d = pos_q + PW'(1);
                    end else begin
                        pos_d = pos_q - PW'(1);
                    end
                end
                M_FRZ: pos_d = pos_q;
                default: pos_d = pos_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q <= 1'b1;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    // Without bounce support, mode 10 behaves as rotate-left
    always_comb begin
        pos_d = pos_q;
        if (step) begin
            unique case (mode_s)
                M_ROL: pos_d = pos_up;
                M_ROR: pos_d = pos_dn;
                M_BNC: pos_d = pos_up;
                M_FRZ: pos_d = pos_q;
                default: pos_d = pos_q;
            endcase
        end
    end
`endif

    always_comb begin
        sel_d   = N_LED'(1) << pos_d;
        pulse_d = step;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pos_q   <= '0;
            sel_q   <= N_LED'(1);
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            sel_q   <= sel_d;
            pulse_q <= pulse_d;
        end
    end

    assign led_select = sel_q;
    assign led_pos    = pos_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer (N_LED=8, STEP_DIV=4): vector table,
// directed corner sequences and random stimulus against a reference model.
module tb_led_sequencer;

    localparam int NL = 8;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic          step_now;
    logic [NL-1:0] led_select;
    logic [2:0]    led_pos;
    logic          step_pulse;

    int vecs = 0;
    int errs = 0;

    // reference model state
    int m_cnt;
    int m_pos;
    int m_dir;
    int m_pulse;

    led_sequencer #(.N_LED(NL), .STEP_DIV(SD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .step_now  (step_now),
        .led_select(led_select),
        .led_pos   (led_pos),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] mode;
        logic       sn;
        int         pos;
        int         pulse;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Bounce as a walk around a ring of 2N-2 phases
    task automatic model_bounce();
        int ring;
        int ph;
        ring = 2 * NL - 2;
        ph = (m_dir != 0) ? m_pos : (ring - m_pos) % ring;
        ph = (ph + 1) % ring;
        m_pos = (ph < NL) ? ph : ring - ph;
        m_dir = (ph >= 1 && ph <= NL - 1) ? 1 : 0;
    endtask

    task automatic model_edge();
        int ev;
        if (!rst_n) begin
            m_cnt = 0; m_pos = 0; m_dir = 1; m_pulse = 0;
            return;
        end
        ev = (step_now || (en && m_cnt == SD - 1)) ? 1 : 0;
        if (step_now) m_cnt = 0;
        else if (en) m_cnt = (m_cnt + 1) % SD;
        m_pulse = ev;
        if (ev == 0) return;
        case (mode)
            2'b00: m_pos = (m_pos + 1) % NL;
            2'b01: m_pos = (m_pos + NL - 1) % NL;
`ifdef LED_SEQ_BOUNCE_EN
            2'b10: model_bounce();
`else
            2'b10: m_pos = (m_pos + 1) % NL;
`endif
            default: ;
        endcase
    endtask

    task automatic tick(input logic r, input logic e,
                        input logic [1:0] m, input logic s);
        rst_n = r; en = e; mode = m; step_now = s;
        model_edge();
        @(posedge clk);
        #1;
        chk("led_select", int'(led_select), 1 << m_pos);
        chk("led_pos", int'(led_pos), m_pos);
        chk("step_pulse", int'(step_pulse), m_pulse);
    endtask

    task automatic add(input logic r, input logic e, input logic [1:0] m,
                       input logic s, input int p, input int pl);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.sn = s;
        v.pos = p; v.pulse = pl;
        tbl.push_back(v);
    endtask

    initial begin
        int pulses;
        int hold_pos;
        int exp_b[16];
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; step_now = 1'b0;
        m_cnt = 0; m_pos = 0; m_dir = 1; m_pulse = 0;
        #1;

        add(0,1,0,0, 0,0); add(1,1,0,0, 0,0); add(1,1,0,0, 0,0);
        add(1,1,0,0, 0,0); add(1,1,0,0, 1,1); add(1,1,0,0, 1,0);
        add(1,0,0,0, 1,0); add(1,0,0,1, 2,1); add(1,0,0,1, 3,1);
        add(1,1,1,0, 3,0); add(1,1,1,0, 3,0); add(1,1,1,0, 3,0);
        add(1,1,1,0, 2,1); add(0,1,1,0, 0,0); add(1,1,1,0, 0,0);
        add(1,1,1,0, 0,0); add(1,1,1,0, 0,0); add(1,1,1,0, 7,1);
        add(1,1,0,0, 7,0); add(1,1,0,0, 7,0); add(1,1,0,0, 7,0);
        add(1,1,0,1, 0,1); add(1,1,0,0, 0,0); add(1,1,0,0, 0,0);
        add(1,1,0,0, 0,0); add(1,1,0,0, 1,1);
        foreach (tbl[i]) begin
            tick(tbl[i].rst_n, tbl[i].en, tbl[i].mode, tbl[i].sn);
            chk($sformatf("tbl%0d_sel", i), int'(led_select),
                1 << tbl[i].pos);
            chk($sformatf("tbl%0d_pulse", i), int'(step_pulse),
                tbl[i].pulse);
        end

        // full rotate-left revolution with wrap at cycle 32
        tick(0, 1, 0, 0);
        pulses = 0;
        for (int c = 1; c <= 32; c++) begin
            tick(1, 1, 0, 0);
            pulses += int'(step_pulse);
            if (c == 28) chk("rol_c28", int'(led_select), 8'h80);
            if (c == 32) chk("rol_c32", int'(led_select), 8'h01);
        end
        chk("rol_pulses", pulses, 8);

        // enable held low at cnt=2, then resume
        tick(0, 1, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1, 0, 0, 0);
            pulses += int'(step_pulse);
        end
        chk("hold_no_step", pulses, 0);
        tick(1, 1, 0, 0);
        chk("hold_cnt3", int'(step_pulse), 0);
        tick(1, 1, 0, 0);
        chk("hold_resume", int'(step_pulse), 1);
        chk("hold_pos", int'(led_pos), 1);

        // freeze for three periods, then resume rotation
        hold_pos = int'(led_pos);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1, 1, 2'b11, 0);
            pulses += int'(step_pulse);
        end
        chk("frz_pulses", pulses, 3);
        chk("frz_pos", int'(led_pos), hold_pos);
        for (int c = 0; c < 4; c++) tick(1, 1, 2'b00, 0);
        chk("frz_resume", int'(led_pos), (hold_pos + 1) % NL);

        // bounce sweep by manual steps
`ifdef LED_SEQ_BOUNCE_EN
        exp_b = '{1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2};
`else
        exp_b = '{1,2,3,4,5,6,7,0,1,2,3,4,5,6,7,0};
`endif
        tick(0, 0, 0, 0);
        for (int c = 0; c < 16; c++) begin
            tick(1, 0, 2'b10, 1);
            chk($sformatf("bnc%0d", c), int'(led_pos), exp_b[c]);
        end

        // reset while descending at pos 5
        tick(0, 0, 0, 0);
        for (int c = 0; c < 9; c++) tick(1, 0, 2'b10, 1);
`ifdef LED_SEQ_BOUNCE_EN
        chk("bnc_at5", int'(led_pos), 5);
`else
        chk("bnc_at5", int'(led_pos), 1);
`endif
        tick(0, 1, 2'b10, 1);
        chk("rst_sel", int'(led_select), 1);
        chk("rst_pulse", int'(step_pulse), 0);
        tick(1, 0, 2'b10, 1);
        chk("rst_up1", int'(led_pos), 1);
        tick(1, 0, 2'b10, 1);
        chk("rst_up2", int'(led_pos), 2);

        // random stimulus
        for (int c = 0; c < 3000; c++) begin
            tick(($urandom_range(63) != 0),
                 ($urandom_range(3) != 0),
                 2'($urandom_range(3)),
                 ($urandom_range(7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
